// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the alu_issue slice: the
//               opcode type, the default data width and the command FIFO
//               entry. The fwd bit exists in the entry only when
//               ALU_ISSUE_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   // Default operand/result width of the issue block.
   localparam int ALU_DATA_W = 32;

   // Operand storage ceiling of a FIFO entry; DATA_W must not exceed this.
   localparam int ALU_MAX_W  = 64;

   typedef logic [2:0] t_alu_op;

   typedef struct packed {
      logic [ALU_MAX_W-1:0] in1;
      logic [ALU_MAX_W-1:0] in2;
      t_alu_op              opcode;
`ifdef ALU_ISSUE_FWD_EN
      logic                 fwd;
`endif
   } t_alu_cmd;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Power-of-two command FIFO for alu_issue. Head entry is
//               presented combinationally; pointers wrap naturally by width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  t_alu_cmd               push_data,
   input  logic                   pop,
   output t_alu_cmd               head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   t_alu_cmd             mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q,  count_d;
   logic                 w_wr, w_rd;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // Qualify requests so the count can never overflow or underflow.
   always_comb begin
      w_wr     = push & ~full;
      w_rd     = pop  & ~empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_wr, w_rd})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy state, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (w_wr) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// ============================================================================
// Module      : alu_issue
// Description : Queues ALU commands, drives an external combinational ALU
//               from the FIFO head and registers its result into a
//               valid/ready response stage.
//               Optional macro ALU_ISSUE_FWD_EN: a head entry with fwd=1
//               takes operand 1 from the last popped result.
//               DATA_W must not exceed alu_pkg::ALU_MAX_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [DATA_W-1:0]      cmd_in1,
   input  logic [DATA_W-1:0]      cmd_in2,
   input  logic [2:0]             cmd_opcode,
   input  logic                   cmd_fwd,
   output logic [DATA_W-1:0]      alu_in1,
   output logic [DATA_W-1:0]      alu_in2,
   output logic [2:0]             alu_opcode,
   input  logic [DATA_W-1:0]      alu_out,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_data,
   output logic [2:0]             rsp_opcode,
   output logic [$clog2(DEPTH):0] occupancy
);

   t_alu_cmd            w_push_cmd;
   t_alu_cmd            w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_unused_ok;

   logic                rdy_en_q;
   logic                rsp_valid_q,   rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q,    rsp_data_d;
   t_alu_op             rsp_opcode_q,  rsp_opcode_d;
   logic [DATA_W-1:0]   last_result_q, last_result_d;

   // Ready is held low in reset and rises on the first edge after release.
   assign cmd_ready = rdy_en_q & ~w_full;
   assign w_push    = cmd_valid & cmd_ready;
   // Empty comes from registered count, so a push into an empty FIFO
   // cannot pop in the same cycle.
   assign w_pop     = ~w_empty & (~rsp_valid_q | rsp_ready);

   // Pack the incoming command into a FIFO entry.
   always_comb begin
      w_push_cmd        = '0;
      w_push_cmd.in1    = ALU_MAX_W'(cmd_in1);
      w_push_cmd.in2    = ALU_MAX_W'(cmd_in2);
      w_push_cmd.opcode = cmd_opcode;
`ifdef ALU_ISSUE_FWD_EN
      w_push_cmd.fwd    = cmd_fwd;
`endif
   end

   // Upper storage bits and, in the base build, the fwd input are unused.
   assign w_unused_ok = ^{w_head, cmd_fwd};

   alu_cmd_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_push_cmd),
      .pop       (w_pop),
      .head      (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (occupancy)
   );

   // Drive the ALU from the head entry; all zero while the FIFO is empty.
   always_comb begin
      alu_in1    = '0;
      alu_in2    = '0;
      alu_opcode = '0;
      if (!w_empty) begin
         alu_in1    = w_head.in1[DATA_W-1:0];
`ifdef ALU_ISSUE_FWD_EN
         if (w_head.fwd) alu_in1 = last_result_q;
`endif
         alu_in2    = w_head.in2[DATA_W-1:0];
         alu_opcode = w_head.opcode;
      end
   end

   // Response stage: capture on pop, drop valid once consumed, else hold.
   always_comb begin
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_opcode_d  = rsp_opcode_q;
      last_result_d = last_result_q;
      if (w_pop) begin
         rsp_valid_d   = 1'b1;
         rsp_data_d    = alu_out;
         rsp_opcode_d  = alu_opcode;
         last_result_d = alu_out;
      end else if (rsp_ready) begin
         rsp_valid_d   = 1'b0;
      end
   end

   // Response, forwarding and ready-enable registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_opcode_q  <= '0;
         last_result_q <= '0;
      end else begin
         rdy_en_q      <= 1'b1;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_opcode_q  <= rsp_opcode_d;
         last_result_q <= last_result_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_opcode = rsp_opcode_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// Module      : tb_alu_issue
// Description : Self-checking bench for alu_issue with an adder stub ALU.
//               Expectations depend on ALU_ISSUE_FWD_EN where relevant.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_issue;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_in1 = '0;
   logic [DATA_W-1:0] cmd_in2 = '0;
   logic [2:0]        cmd_opcode = '0;
   logic              cmd_fwd = 1'b0;
   logic [DATA_W-1:0] alu_in1, alu_in2, alu_out;
   logic [2:0]        alu_opcode;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_data;
   logic [2:0]        rsp_opcode;
   logic [CNT_W-1:0]  occupancy;

   alu_issue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_in1    (cmd_in1),
      .cmd_in2    (cmd_in2),
      .cmd_opcode (cmd_opcode),
      .cmd_fwd    (cmd_fwd),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_opcode (alu_opcode),
      .alu_out    (alu_out),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_opcode (rsp_opcode),
      .occupancy  (occupancy)
   );

   // Stub ALU
   assign alu_out = alu_in1 + alu_in2;

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [DATA_W-1:0] got_data [$];
   logic [2:0]        got_op   [$];
   int                got_cyc  [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Response collector and stall-stability monitor
   logic              mon_stall = 1'b0;
   logic [DATA_W-1:0] mon_data  = '0;
   logic [2:0]        mon_op    = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_stall = 1'b0;
      end else begin
         if (mon_stall) begin
            check("hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold_data", {32'd0, rsp_data}, {32'd0, mon_data});
            check("hold_op", {61'd0, rsp_opcode}, {61'd0, mon_op});
         end
         if (rsp_valid && rsp_ready) begin
            got_data.push_back(rsp_data);
            got_op.push_back(rsp_opcode);
            got_cyc.push_back(cyc);
         end
         mon_stall = rsp_valid && !rsp_ready;
         mon_data  = rsp_data;
         mon_op    = rsp_opcode;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_got();
      got_data.delete();
      got_op.delete();
      got_cyc.delete();
   endtask

   // Present a command from posedge+1 until accepted (bounded).
   task automatic push_cmd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [2:0] op, input logic f);
      int n;
      n = 0;
      cmd_valid = 1'b1; cmd_in1 = a; cmd_in2 = b; cmd_opcode = op; cmd_fwd = f;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!cmd_ready) check("push_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_got(input int want, input int budget);
      int n;
      n = 0;
      while (got_data.size() < want && n < budget) begin
         n++;
         tick();
      end
   endtask

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [2:0]        op;
      logic [DATA_W-1:0] exp;
   } vec_t;

   vec_t              vecs [8];
   logic [DATA_W-1:0] exp_data [$];
   logic [2:0]        exp_op   [$];
   logic              stop_rdy = 1'b0;

   initial begin
      vecs[0] = '{32'd1,          32'd1,          3'd1, 32'd2};
      vecs[1] = '{32'd100,        32'd23,         3'd2, 32'd123};
      vecs[2] = '{32'hFFFF_FFFF,  32'd1,          3'd3, 32'd0};
      vecs[3] = '{32'h8000_0000,  32'h8000_0000,  3'd4, 32'd0};
      vecs[4] = '{32'h1234_5678,  32'h1111_1111,  3'd5, 32'h2345_6789};
      vecs[5] = '{32'd0,          32'd0,          3'd6, 32'd0};
      vecs[6] = '{32'hDEAD_0000,  32'h0000_BEEF,  3'd7, 32'hDEAD_BEEF};
      vecs[7] = '{32'd7,          32'd8,          3'd0, 32'd15};

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check("rst_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_data", {32'd0, rsp_data}, 64'd0);
      check("rst_op", {61'd0, rsp_opcode}, 64'd0);
      check("rst_occ", {61'd0, occupancy}, 64'd0);
      check("rst_ready", {63'd0, cmd_ready}, 64'd0);
      check("rst_alu_in1", {32'd0, alu_in1}, 64'd0);
      #2 rst_n = 1'b1;
      tick();
      check("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

      // ---- single command, two-cycle latency ----
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_in1 = 32'd5; cmd_in2 = 32'd2; cmd_opcode = 3'd0; cmd_fwd = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("lat_n1_valid", {63'd0, rsp_valid}, 64'd0);
      check("lat_n1_in1", {32'd0, alu_in1}, 64'd5);
      check("lat_n1_in2", {32'd0, alu_in2}, 64'd2);
      check("lat_n1_occ", {61'd0, occupancy}, 64'd1);
      @(negedge clk);
      check("lat_n2_valid", {63'd0, rsp_valid}, 64'd1);
      check("lat_n2_data", {32'd0, rsp_data}, 64'd7);
      check("lat_n2_op", {61'd0, rsp_opcode}, 64'd0);
      check("lat_n2_occ", {61'd0, occupancy}, 64'd0);
      tick(); tick();
      clear_got();

      // ---- table stream: 8 back-to-back commands, ready high ----
      for (int i = 0; i < 8; i++) push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0);
      wait_got(8, 20);
      check("stream_count", 64'(got_data.size()), 64'd8);
      for (int i = 0; i < 8 && i < got_data.size(); i++) begin
         check($sformatf("stream_data[%0d]", i), {32'd0, got_data[i]}, {32'd0, vecs[i].exp});
         check($sformatf("stream_op[%0d]", i), {61'd0, got_op[i]}, {61'd0, vecs[i].op});
         if (i > 0)
            check($sformatf("stream_consec[%0d]", i), 64'(got_cyc[i]), 64'(got_cyc[i-1] + 1));
      end
      tick(); tick();
      clear_got();

      // ---- backpressure: 5 pushes with ready low ----
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_cmd(32'(10*i + 1), 32'(i), 3'(i), 1'b0);
      @(negedge clk);
      check("bp_occ", {61'd0, occupancy}, 64'd4);
      check("bp_ready", {63'd0, cmd_ready}, 64'd0);
      check("bp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_head_rsp", {32'd0, rsp_data}, 64'd1);
      // a sixth command offered while full must be refused
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_in1 = 32'd999; cmd_in2 = 32'd1; cmd_opcode = 3'd7;
      repeat (3) tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_occ_full", {61'd0, occupancy}, 64'd4);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_got(5, 30);
      repeat (4) tick();
      check("bp_count", 64'(got_data.size()), 64'd5);
      for (int i = 0; i < 5 && i < got_data.size(); i++) begin
         check($sformatf("bp_data[%0d]", i), {32'd0, got_data[i]}, 64'(11*i + 1));
         check($sformatf("bp_op[%0d]", i), {61'd0, got_op[i]}, 64'(i));
      end
      clear_got();

      // ---- forwarding ----
      push_cmd(32'd5, 32'd2, 3'd1, 1'b0);
      push_cmd(32'd9, 32'd3, 3'd2, 1'b1);
      wait_got(2, 20);
      check("fwd_count", 64'(got_data.size()), 64'd2);
      if (got_data.size() >= 2) begin
         check("fwd_first", {32'd0, got_data[0]}, 64'd7);
`ifdef ALU_ISSUE_FWD_EN
         check("fwd_second", {32'd0, got_data[1]}, 64'd10);
`else
         check("fwd_second", {32'd0, got_data[1]}, 64'd12);
`endif
      end
      tick(); tick();
      clear_got();

      // ---- reset mid-operation ----
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_cmd(32'(i + 3), 32'd1, 3'd3, 1'b0);
      @(negedge clk);
      check("mid_pre_occ", {61'd0, occupancy}, 64'd3);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
      check("mid_rst_occ", {61'd0, occupancy}, 64'd0);
      check("mid_rst_ready", {63'd0, cmd_ready}, 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      rsp_ready = 1'b1;
      clear_got();
      repeat (8) tick();
      check("mid_no_stale", 64'(got_data.size()), 64'd0);
      check("mid_occ_after", {61'd0, occupancy}, 64'd0);
      check("mid_ready_after", {63'd0, cmd_ready}, 64'd1);
      clear_got();

      // ---- random ready over 50 commands ----
      fork
         begin
            logic [DATA_W-1:0] a, b;
            logic [2:0]        op;
            for (int i = 0; i < 50; i++) begin
               a  = $urandom;
               b  = $urandom;
               op = 3'($urandom_range(0, 7));
               exp_data.push_back(a + b);
               exp_op.push_back(op);
               push_cmd(a, b, op, 1'b0);
            end
            stop_rdy = 1'b1;
         end
         begin
            while (!stop_rdy) begin
               @(posedge clk); #1;
               rsp_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_got(50, 300);
      repeat (4) tick();
      check("rand_count", 64'(got_data.size()), 64'd50);
      for (int i = 0; i < 50 && i < got_data.size(); i++) begin
         check($sformatf("rand_data[%0d]", i), {32'd0, got_data[i]}, {32'd0, exp_data[i]});
         check($sformatf("rand_op[%0d]", i), {61'd0, got_op[i]}, {61'd0, exp_op[i]});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width.
REQ-002 Parameter DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  upstream command valid.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_in1  input  DATA_W  operand 1.
REQ-008 cmd_in2  input  DATA_W  operand 2.
REQ-009 cmd_opcode  input  3  ALU opcode, passed through unmodified.
REQ-010 cmd_fwd  input  1  replace operand 1 with the last result (see Configuration).
REQ-011 alu_in1  output  DATA_W  to the combinational alu in1.
REQ-012 alu_in2  output  DATA_W  to the alu in2.
REQ-013 alu_opcode  output  3  to the alu opcode.
REQ-014 alu_out  input  DATA_W  from the alu out; treated as combinational, same cycle.
REQ-015 rsp_valid  output  1  result valid.
REQ-016 rsp_ready  input  1  downstream accepts the result.
REQ-017 rsp_data  output  DATA_W  registered ALU result.
REQ-018 rsp_opcode  output  3  opcode that produced rsp_data.
REQ-019 occupancy  output  $clog2(DEPTH)+1  FIFO entries currently held.

Function
REQ-020 A push occurs when cmd_valid and cmd_ready are both high; it stores {in1, in2, opcode, fwd} at the tail.
REQ-021 cmd_ready SHALL equal (occupancy != DEPTH); it does not depend on pop in the same cycle.
REQ-022 alu_in1, alu_in2 and alu_opcode SHALL be driven from the FIFO head entry, and SHALL be all-zero when the FIFO is empty.
REQ-023 A pop occurs when the FIFO is non-empty and (rsp_valid is low or rsp_ready is high).
REQ-024 On a pop, rsp_data takes alu_out, rsp_opcode takes the head opcode, and rsp_valid is set.
REQ-025 When rsp_valid and rsp_ready are high and no pop occurs, rsp_valid SHALL clear.
REQ-026 While rsp_valid is high and rsp_ready is low, rsp_data and rsp_opcode SHALL hold stable.
REQ-027 Latency: a command pushed in cycle N SHALL give rsp_valid in cycle N+2 when the FIFO was empty and the result register was free.
REQ-028 Sustained throughput SHALL be one command per cycle while rsp_ready is high.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 occupancy SHALL be exact at all times, with no overflow or underflow.
REQ-032 A push into an empty FIFO SHALL NOT pop in the same cycle.
REQ-033 A register last_result SHALL update with alu_out on every pop, independent of rsp_ready.

Reset
REQ-034 On rst_n low: FIFO emptied, occupancy 0, cmd_ready 0 while in reset, rsp_valid 0, rsp_data 0, rsp_opcode 0, last_result 0.
REQ-035 After release, cmd_ready SHALL rise in the first clock cycle.
REQ-036 Reset mid-operation SHALL discard all queued and in-flight commands; no response is produced for them.

Configuration
REQ-037 Macro ALU_ISSUE_FWD_EN defined: when the head entry has fwd=1, alu_in1 SHALL be last_result instead of the stored in1.
REQ-038 Macro undefined: cmd_fwd is accepted but ignored, no fwd bit is stored, and alu_in1 is always the stored in1.

Structure
REQ-039 Package alu_pkg SHALL hold the opcode typedef t_alu_op (3-bit), the DATA_W default constant, and the FIFO entry struct t_alu_cmd.
REQ-040 The FIFO SHALL be a sub-module alu_cmd_fifo with push, pop, full, empty and count ports; the ALU is instantiated outside this block.

Verification (bench stub ALU: alu_out = alu_in1 + alu_in2)
REQ-041 Push (5, 2, 000), rsp_ready=1 -> two cycles later rsp_valid=1, rsp_data=7, rsp_opcode=000.
REQ-042 Push 5 commands back-to-back with rsp_ready=0, DEPTH=4 -> one command held in the response register plus 4 queued; cmd_ready low thereafter; occupancy=4; no data lost after rsp_ready=1.
REQ-043 Stream 8 commands with rsp_ready=1 -> 8 responses on consecutive cycles, in order, pointers wrapped.
REQ-044 With ALU_ISSUE_FWD_EN: push (5, 2) then (9, 3, fwd=1) -> responses 7 then 10; without the macro -> 7 then 12.
REQ-045 Assert rst_n low with 3 commands queued -> rsp_valid=0 and occupancy=0 immediately; no stale response after release.
REQ-046 Toggle rsp_ready randomly every cycle over 50 commands -> rsp_data stable while stalled, no drops, no duplicates.
